// File: rtl/load_store_unit.sv
// Load/store sequencer ahead of the synchronous RAM: accept, check, issue, capture, respond.
// Latency accept->resp_valid: load 3, store 2, fault 1; a held response stalls new requests.
module load_store_unit #(
  parameter logic [31:0] ADDR_LIMIT = 32'd262144
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_op,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_data,
  output logic        resp_is_load,
  output logic [1:0]  resp_fault,
  output logic [31:0] fault_addr
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] ea_q, ea_d;
  logic [7:0]  op_q, op_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic [1:0]  fault_q, fault_d;
  logic        store_q, store_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] ea;
  logic [7:0]  req_op;
  logic [1:0]  req_fault;
  logic        mem_busy;

  assign ea = req_base + req_offset;

  always_comb begin
    req_op = 8'd0;
    if (req_is_store) begin
      case (req_funct3)
        3'b000:  req_op = 8'd6;
        3'b001:  req_op = 8'd7;
        3'b010:  req_op = 8'd8;
        default: req_op = 8'd0;
      endcase
    end else begin
      case (req_funct3)
        3'b000:  req_op = 8'd1;
        3'b001:  req_op = 8'd2;
        3'b010:  req_op = 8'd3;
        3'b100:  req_op = 8'd4;
        3'b101:  req_op = 8'd5;
        default: req_op = 8'd0;
      endcase
    end

    // funct3[1:0] encodes the access size for every legal code: 00 byte, 01 half, 10 word
    req_fault = 2'd0;
    if (req_op == 8'd0) begin
      req_fault = 2'd1;
    end else if ((req_funct3[1:0] == 2'b01 && ea[0]) ||
                 (req_funct3[1:0] == 2'b10 && ea[1:0] != 2'b00)) begin
      req_fault = 2'd2;
    end else if (ea >= ADDR_LIMIT) begin
      req_fault = 2'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ea_q    <= 32'd0;
      op_q    <= 8'd0;
      wdata_q <= 32'd0;
      rd_q    <= 5'd0;
      fault_q <= 2'd0;
      store_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      ea_q    <= ea_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      fault_q <= fault_d;
      store_q <= store_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ea_d    = ea_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    fault_d = fault_q;
    store_d = store_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          ea_d    = ea;
          op_d    = req_op;
          wdata_d = req_is_store ? req_wdata : 32'd0;
          rd_d    = req_rd;
          fault_d = req_fault;
          store_d = req_is_store;
          rdata_d = 32'd0;
          state_d = (req_fault != 2'd0) ? RESP : ISSUE;
        end
      end
      ISSUE:   state_d = store_q ? RESP : CAPTURE;
      CAPTURE: begin
        rdata_d = mem_data_out;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Op and address stay up through CAPTURE so the RAM side can format the returning word
  assign mem_busy     = (state_q == ISSUE) || (state_q == CAPTURE);
  assign req_ready    = (state_q == IDLE);
  assign mem_op       = mem_busy ? op_q : 8'd0;
  assign mem_addr     = mem_busy ? ea_q : 32'd0;
  assign mem_data_in  = (state_q == ISSUE) ? wdata_q : 32'd0;

  assign resp_valid   = (state_q == RESP);
  assign resp_rd      = resp_valid ? rd_q : 5'd0;
  assign resp_data    = resp_valid ? rdata_q : 32'd0;
  assign resp_is_load = resp_valid && !store_q && (fault_q == 2'd0);
  assign resp_fault   = resp_valid ? fault_q : 2'd0;
  assign fault_addr   = (resp_valid && fault_q != 2'd0) ? ea_q : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit with a behavioural RAM model and a response scoreboard.
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk, rst;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base, req_offset, req_wdata;
  logic [4:0]  req_rd;
  logic [31:0] mem_addr, mem_data_in, mem_data_out;
  logic [7:0]  mem_op;
  logic        resp_valid, resp_ready, resp_is_load;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data, fault_addr;
  logic [1:0]  resp_fault;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_addr(mem_addr), .mem_op(mem_op), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd(resp_rd),
    .resp_data(resp_data), .resp_is_load(resp_is_load), .resp_fault(resp_fault),
    .fault_addr(fault_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: one-cycle read, lane placement on write, formatting from the held op/addr
  logic [31:0] mem [0:255];
  logic [31:0] rword_q, wmask, wshift;
  logic        mem_clr;

  always_comb begin
    wmask  = 32'hFFFF_FFFF;
    wshift = mem_data_in;
    if (mem_op == 8'd6) begin
      wmask  = 32'h0000_00FF << {mem_addr[1:0], 3'b000};
      wshift = {24'd0, mem_data_in[7:0]} << {mem_addr[1:0], 3'b000};
    end else if (mem_op == 8'd7) begin
      wmask  = 32'h0000_FFFF << {mem_addr[1], 4'b0000};
      wshift = {16'd0, mem_data_in[15:0]} << {mem_addr[1], 4'b0000};
    end
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
    end else if (mem_op >= 8'd6 && mem_op <= 8'd8) begin
      mem[mem_addr[9:2]] <= (mem[mem_addr[9:2]] & ~wmask) | (wshift & wmask);
    end else if (mem_op >= 8'd1 && mem_op <= 8'd5) begin
      rword_q <= mem[mem_addr[9:2]];
    end
  end

  always_comb begin
    logic [31:0] bs, hs;
    bs = rword_q >> {mem_addr[1:0], 3'b000};
    hs = rword_q >> {mem_addr[1], 4'b0000};
    case (mem_op)
      8'd1:    mem_data_out = {{24{bs[7]}}, bs[7:0]};
      8'd2:    mem_data_out = {{16{hs[15]}}, hs[15:0]};
      8'd3:    mem_data_out = rword_q;
      8'd4:    mem_data_out = {24'd0, bs[7:0]};
      8'd5:    mem_data_out = {16'd0, hs[15:0]};
      default: mem_data_out = 32'd0;
    endcase
  end

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        is_load;
    logic [1:0]  fault;
    logic [31:0] faddr;
  } resp_t;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] base, off, wd;
    logic [4:0]  rd;
    resp_t       exp;
    int          lat, opc;
    logic [7:0]  op;
    logic [31:0] addr, wd_exp;
  } stim_t;

  resp_t sb[$];
  int tests_run = 0;
  int tests_failed = 0;

  resp_t       r_obs, r_exp;
  int          r_lat, r_opc;
  logic [7:0]  r_op0;
  logic [31:0] r_a0, r_d0;
  longint      r_acc, prev_acc, t_rel;

  function automatic stim_t mk(input logic st, input logic [2:0] f3, input logic [31:0] base,
                               input logic [31:0] off, input logic [31:0] wd, input logic [4:0] rd,
                               input logic [31:0] data, input logic [1:0] fault, input logic [7:0] op);
    stim_t s;
    logic [31:0] ea;
    ea = base + off;
    s.st = st; s.f3 = f3; s.base = base; s.off = off; s.wd = wd; s.rd = rd;
    s.exp    = {rd, (st || fault != 2'd0) ? 32'd0 : data, (!st && fault == 2'd0), fault,
                (fault != 2'd0) ? ea : 32'd0};
    s.lat    = (fault != 2'd0) ? 1 : (st ? 2 : 3);
    s.opc    = (fault != 2'd0) ? 0 : (st ? 1 : 2);
    s.op     = (fault != 2'd0) ? 8'd0 : op;
    s.addr   = (fault != 2'd0) ? 32'd0 : ea;
    s.wd_exp = (fault == 2'd0 && st) ? wd : 32'd0;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    req_is_store = s.st;
    req_funct3   = s.f3;
    req_base     = s.base;
    req_offset   = s.off;
    req_wdata    = s.wd;
    req_rd       = s.rd;
  endtask

  // Presents one request, records memory-side activity and the response fields
  task automatic run_req(input stim_t s, output resp_t obs, output int lat, output int opc,
                         output logic [7:0] op0, output logic [31:0] a0, output logic [31:0] d0,
                         output longint acc);
    obs = '0; lat = -1; opc = 0; op0 = 8'd0; a0 = 32'd0; d0 = 32'd0;
    @(negedge clk);
    drive(s);
    req_valid  = 1'b1;
    resp_ready = 1'b1;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    @(posedge clk);
    acc = $time;
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_op != 8'd0) begin
        if (opc == 0) begin op0 = mem_op; a0 = mem_addr; d0 = mem_data_in; end
        opc++;
      end
      if (resp_valid) begin
        lat = c;
        obs = {resp_rd, resp_data, resp_is_load, resp_fault, fault_addr};
        break;
      end
    end
    if (lat >= 0) @(posedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({req_ready, resp_valid, mem_op, mem_addr, mem_data_in, resp_rd, resp_data,
         resp_is_load, resp_fault, fault_addr} !== {1'b1, 1'b0, 8'd0, 32'd0, 32'd0, 5'd0,
         32'd0, 1'b0, 2'd0, 32'd0}) begin
      tests_failed++;
      $display("FAIL reset_state: got rdy=%b vld=%b op=%0d addr=%h", req_ready, resp_valid, mem_op, mem_addr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mem_clr = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({req_ready, resp_valid, mem_op} !== {1'b1, 1'b0, 8'd0}) begin
      tests_failed++;
      $display("FAIL post_reset_idle: got rdy=%b vld=%b op=%0d want 1 0 0", req_ready, resp_valid, mem_op);
    end
  endtask

  task automatic test_sw_lw;
    stim_t t[2];
    t[0] = mk(1'b1, 3'b010, 32'h100, 32'h4, 32'hDEADBEEF, 5'd1, 32'd0, 2'd0, 8'd8);
    t[1] = mk(1'b0, 3'b010, 32'h100, 32'h4, 32'h0, 5'd5, 32'hDEADBEEF, 2'd0, 8'd3);
    foreach (t[i]) begin
      sb.push_back(t[i].exp);
      run_req(t[i], r_obs, r_lat, r_opc, r_op0, r_a0, r_d0, r_acc);
      r_exp = sb.pop_front();
      tests_run++;
      if (r_obs !== r_exp) begin tests_failed++; $display("FAIL sw_lw[%0d] resp: got %h want %h", i, r_obs, r_exp); end
      tests_run++;
      if ({r_lat, r_opc, r_op0, r_a0, r_d0} !== {t[i].lat, t[i].opc, t[i].op, t[i].addr, t[i].wd_exp}) begin
        tests_failed++;
        $display("FAIL sw_lw[%0d] seq: got lat=%0d opc=%0d op=%0d addr=%h d=%h want lat=%0d opc=%0d op=%0d addr=%h d=%h",
                 i, r_lat, r_opc, r_op0, r_a0, r_d0, t[i].lat, t[i].opc, t[i].op, t[i].addr, t[i].wd_exp);
      end
    end
  endtask

  task automatic test_byte_ext;
    stim_t t[8];
    t[0] = mk(1'b1, 3'b000, 32'h200, 32'h1, 32'h0000_0080, 5'd2, 32'd0, 2'd0, 8'd6);
    t[1] = mk(1'b0, 3'b000, 32'h200, 32'h1, 32'h0, 5'd3, 32'hFFFF_FF80, 2'd0, 8'd1);
    t[2] = mk(1'b0, 3'b100, 32'h200, 32'h1, 32'h0, 5'd4, 32'h0000_0080, 2'd0, 8'd4);
    t[3] = mk(1'b1, 3'b001, 32'h200, 32'h2, 32'h1234_8001, 5'd6, 32'd0, 2'd0, 8'd7);
    t[4] = mk(1'b0, 3'b001, 32'h200, 32'h2, 32'h0, 5'd7, 32'hFFFF_8001, 2'd0, 8'd2);
    t[5] = mk(1'b0, 3'b101, 32'h200, 32'h2, 32'h0, 5'd8, 32'h0000_8001, 2'd0, 8'd5);
    t[6] = mk(1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 5'd9, 32'h8001_8000, 2'd0, 8'd3);
    t[7] = mk(1'b0, 3'b100, 32'h204, 32'hFFFF_FFFD, 32'h0, 5'd10, 32'h0000_0080, 2'd0, 8'd4);
    foreach (t[i]) begin
      sb.push_back(t[i].exp);
      run_req(t[i], r_obs, r_lat, r_opc, r_op0, r_a0, r_d0, r_acc);
      r_exp = sb.pop_front();
      tests_run++;
      if (r_obs !== r_exp) begin tests_failed++; $display("FAIL byte_ext[%0d] resp: got %h want %h", i, r_obs, r_exp); end
      tests_run++;
      if ({r_lat, r_opc, r_op0, r_a0, r_d0} !== {t[i].lat, t[i].opc, t[i].op, t[i].addr, t[i].wd_exp}) begin
        tests_failed++;
        $display("FAIL byte_ext[%0d] seq: got lat=%0d opc=%0d op=%0d addr=%h want lat=%0d opc=%0d op=%0d addr=%h",
                 i, r_lat, r_opc, r_op0, r_a0, t[i].lat, t[i].opc, t[i].op, t[i].addr);
      end
    end
  endtask

  task automatic test_faults;
    stim_t t[11];
    t[0]  = mk(1'b0, 3'b001, 32'h200, 32'h3, 32'h0, 5'd11, 32'd0, 2'd2, 8'd0);
    t[1]  = mk(1'b0, 3'b010, 32'h40000, 32'h0, 32'h0, 5'd12, 32'd0, 2'd3, 8'd0);
    t[2]  = mk(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 5'd13, 32'd0, 2'd1, 8'd0);
    t[3]  = mk(1'b0, 3'b110, 32'h100, 32'h0, 32'h0, 5'd14, 32'd0, 2'd1, 8'd0);
    t[4]  = mk(1'b1, 3'b011, 32'h100, 32'h0, 32'h5555_5555, 5'd15, 32'd0, 2'd1, 8'd0);
    t[5]  = mk(1'b1, 3'b001, 32'h100, 32'h1, 32'h5555_5555, 5'd16, 32'd0, 2'd2, 8'd0);
    t[6]  = mk(1'b1, 3'b010, 32'h100, 32'h2, 32'h5555_5555, 5'd17, 32'd0, 2'd2, 8'd0);
    t[7]  = mk(1'b0, 3'b111, 32'h40000, 32'h1, 32'h0, 5'd18, 32'd0, 2'd1, 8'd0);
    t[8]  = mk(1'b0, 3'b010, 32'h40000, 32'h2, 32'h0, 5'd19, 32'd0, 2'd2, 8'd0);
    t[9]  = mk(1'b1, 3'b000, 32'h40000, 32'h0, 32'h5555_5555, 5'd20, 32'd0, 2'd3, 8'd0);
    t[10] = mk(1'b0, 3'b000, 32'h0, 32'hFFFF_FFFF, 32'h0, 5'd21, 32'd0, 2'd3, 8'd0);
    foreach (t[i]) begin
      sb.push_back(t[i].exp);
      run_req(t[i], r_obs, r_lat, r_opc, r_op0, r_a0, r_d0, r_acc);
      r_exp = sb.pop_front();
      tests_run++;
      if (r_obs !== r_exp) begin tests_failed++; $display("FAIL faults[%0d] resp: got %h want %h", i, r_obs, r_exp); end
      tests_run++;
      if ({r_lat, r_opc} !== {t[i].lat, t[i].opc}) begin
        tests_failed++;
        $display("FAIL faults[%0d] seq: got lat=%0d opc=%0d want lat=%0d opc=%0d", i, r_lat, r_opc, t[i].lat, t[i].opc);
      end
    end
  endtask

  task automatic test_wrap_range;
    stim_t t[6];
    t[0] = mk(1'b1, 3'b010, 32'h0, 32'h4, 32'h1234_5678, 5'd22, 32'd0, 2'd0, 8'd8);
    t[1] = mk(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h8, 32'h0, 5'd23, 32'h1234_5678, 2'd0, 8'd3);
    t[2] = mk(1'b1, 3'b010, 32'h3FFFC, 32'h0, 32'hCAFE_F00D, 5'd24, 32'd0, 2'd0, 8'd8);
    t[3] = mk(1'b0, 3'b010, 32'h3FFF0, 32'hC, 32'h0, 5'd25, 32'hCAFE_F00D, 2'd0, 8'd3);
    t[4] = mk(1'b0, 3'b100, 32'h3FFFF, 32'h0, 32'h0, 5'd26, 32'h0000_00CA, 2'd0, 8'd4);
    t[5] = mk(1'b0, 3'b001, 32'h3FFFE, 32'h0, 32'h0, 5'd27, 32'hFFFF_CAFE, 2'd0, 8'd2);
    foreach (t[i]) begin
      sb.push_back(t[i].exp);
      run_req(t[i], r_obs, r_lat, r_opc, r_op0, r_a0, r_d0, r_acc);
      r_exp = sb.pop_front();
      tests_run++;
      if (r_obs !== r_exp) begin tests_failed++; $display("FAIL wrap_range[%0d] resp: got %h want %h", i, r_obs, r_exp); end
      tests_run++;
      if ({r_lat, r_opc, r_op0, r_a0, r_d0} !== {t[i].lat, t[i].opc, t[i].op, t[i].addr, t[i].wd_exp}) begin
        tests_failed++;
        $display("FAIL wrap_range[%0d] seq: got lat=%0d opc=%0d op=%0d addr=%h want lat=%0d opc=%0d op=%0d addr=%h",
                 i, r_lat, r_opc, r_op0, r_a0, t[i].lat, t[i].opc, t[i].op, t[i].addr);
      end
    end
  endtask

  task automatic test_back_to_back;
    stim_t t[6];
    t[0] = mk(1'b1, 3'b000, 32'h300, 32'h0, 32'h0000_0055, 5'd1, 32'd0, 2'd0, 8'd6);
    t[1] = mk(1'b0, 3'b100, 32'h300, 32'h0, 32'h0, 5'd2, 32'h0000_0055, 2'd0, 8'd4);
    t[2] = mk(1'b0, 3'b010, 32'h300, 32'h2, 32'h0, 5'd3, 32'd0, 2'd2, 8'd0);
    t[3] = mk(1'b1, 3'b111, 32'h300, 32'h0, 32'h0, 5'd4, 32'd0, 2'd1, 8'd0);
    t[4] = mk(1'b1, 3'b010, 32'h300, 32'h4, 32'hA5A5_0F0F, 5'd5, 32'd0, 2'd0, 8'd8);
    t[5] = mk(1'b0, 3'b010, 32'h304, 32'h0, 32'h0, 5'd6, 32'hA5A5_0F0F, 2'd0, 8'd3);
    prev_acc = 0;
    foreach (t[i]) begin
      sb.push_back(t[i].exp);
      run_req(t[i], r_obs, r_lat, r_opc, r_op0, r_a0, r_d0, r_acc);
      r_exp = sb.pop_front();
      tests_run++;
      if (r_obs !== r_exp) begin tests_failed++; $display("FAIL b2b[%0d] resp: got %h want %h", i, r_obs, r_exp); end
      if (i > 0) begin
        tests_run++;
        if ((r_acc - prev_acc) !== longint'((t[i-1].lat + 1) * 10)) begin
          tests_failed++;
          $display("FAIL b2b[%0d] spacing: got %0d ns want %0d ns", i, r_acc - prev_acc, (t[i-1].lat + 1) * 10);
        end
      end
      prev_acc = r_acc;
    end
  endtask

  task automatic test_backpressure;
    stim_t s, f;
    logic  seen, held;
    s = mk(1'b0, 3'b010, 32'h100, 32'h4, 32'h0, 5'd7, 32'hDEADBEEF, 2'd0, 8'd3);
    sb.push_back(s.exp);
    @(negedge clk);
    drive(s);
    req_valid  = 1'b1;
    resp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = resp_valid;
    end
    tests_run++;
    if (!seen) begin tests_failed++; $display("FAIL bp_resp_timeout: got no resp_valid want resp_valid=1"); end
    r_obs = {resp_rd, resp_data, resp_is_load, resp_fault, fault_addr};
    r_exp = sb.pop_front();
    tests_run++;
    if (r_obs !== r_exp) begin tests_failed++; $display("FAIL bp_resp: got %h want %h", r_obs, r_exp); end
    held = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if ({resp_valid, req_ready, mem_op, resp_data, resp_rd} !== {1'b1, 1'b0, 8'd0, 32'hDEADBEEF, 5'd7}) held = 1'b0;
    end
    tests_run++;
    if (!held) begin
      tests_failed++;
      $display("FAIL bp_hold: got vld=%b rdy=%b op=%0d data=%h want 1 0 0 deadbeef", resp_valid, req_ready, mem_op, resp_data);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    t_rel = $time;
    #1;
    tests_run++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL bp_release_idle: got rdy=%b vld=%b want 1 0", req_ready, resp_valid);
    end
    f = mk(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 5'd8, 32'd0, 2'd1, 8'd0);
    sb.push_back(f.exp);
    run_req(f, r_obs, r_lat, r_opc, r_op0, r_a0, r_d0, r_acc);
    r_exp = sb.pop_front();
    tests_run++;
    if ((r_acc - t_rel) !== 64'sd10) begin
      tests_failed++;
      $display("FAIL bp_next_accept: got %0d ns after release want 10 ns", r_acc - t_rel);
    end
    tests_run++;
    if (r_obs !== r_exp) begin tests_failed++; $display("FAIL bp_next_resp: got %h want %h", r_obs, r_exp); end
  endtask

  task automatic test_reset_midop;
    stim_t ld, st, chk;
    logic  quiet;
    ld = mk(1'b0, 3'b010, 32'h100, 32'h4, 32'h0, 5'd9, 32'hDEADBEEF, 2'd0, 8'd3);
    st = mk(1'b1, 3'b010, 32'h100, 32'h4, 32'hBAD0_BAD0, 5'd10, 32'd0, 2'd0, 8'd8);
    @(negedge clk);
    drive(ld);
    req_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (mem_op !== 8'd3) begin tests_failed++; $display("FAIL capture_op: got %0d want 3", mem_op); end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({mem_op, mem_addr, resp_valid, req_ready} !== {8'd0, 32'd0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_capture: got op=%0d addr=%h vld=%b rdy=%b want 0 0 0 1", mem_op, mem_addr, resp_valid, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    repeat (3) begin @(negedge clk); if (resp_valid !== 1'b0) quiet = 1'b0; end
    tests_run++;
    if (!quiet) begin tests_failed++; $display("FAIL reset_drop: got resp_valid=1 want 0"); end
    drive(st);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    tests_run++;
    if (mem_op !== 8'd8) begin tests_failed++; $display("FAIL issue_op: got %0d want 8", mem_op); end
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
    chk = ld;
    sb.push_back(chk.exp);
    run_req(chk, r_obs, r_lat, r_opc, r_op0, r_a0, r_d0, r_acc);
    r_exp = sb.pop_front();
    tests_run++;
    if (r_obs !== r_exp) begin tests_failed++; $display("FAIL aborted_store: got %h want %h", r_obs, r_exp); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_clr = 1'b1;
    req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
    req_base = 32'd0; req_offset = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
    resp_ready = 1'b1;
    test_reset;
    test_sw_lw;
    test_byte_ext;
    test_faults;
    test_wrap_range;
    test_back_to_back;
    test_backpressure;
    test_reset_midop;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
